gpio_ddr_od_regfile: RTL and testbench

- Parametrised GPIO direction and open-drain register file for the HostMot3 GPIO mux.
- Decodes bus writes and reads to NumIOReg DDR registers at DDRBase and NumIOReg open-drain registers at ODBase.
- Write/read strobes are synchronised and edge-detected in the CLOCK domain; no register is clocked by a strobe.
- Produces per-pin output enables with open-drain emulation, pad drive data, a readback path, and synchronised pad inputs toward hm3.

---
 rtl/gpio_ddr_od_regfile.sv | 136 +++++++++++++
 tb/tb_gpio_ddr_od_regfile.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_ddr_od_regfile.sv
// GPIO direction / open-drain register file for the HostMot3 GPIO mux.
// Bus strobes are synchronised into CLOCK; pins get oe/pad_out with open-drain emulation.
module gpio_ddr_od_regfile #(
    parameter int                   AddrWidth      = 14,
    parameter int                   BusWidth       = 32,
    parameter int                   MuxGPIOIOWidth = 34,
    parameter int                   NumIOReg       = 6,
    parameter int                   PortsPerReg    = 24,
    parameter logic [AddrWidth-1:0] DDRBase        = 14'h1100,
    parameter logic [AddrWidth-1:0] ODBase         = 14'h1300
) (
    input  logic                      CLOCK,
    input  logic                      reset_reg_N,
    input  logic                      write_reg,
    input  logic                      read_reg,
    input  logic [AddrWidth-3:0]      busaddress,
    input  logic [BusWidth-1:0]       busdata_in,
    output logic [BusWidth-1:0]       busdata_out,
    output logic                      read_valid,
    input  logic [MuxGPIOIOWidth-1:0] iodatafromhm3,
    input  logic [MuxGPIOIOWidth-1:0] pad_in,
    output logic [MuxGPIOIOWidth-1:0] oe,
    output logic [MuxGPIOIOWidth-1:0] pad_out,
    output logic [MuxGPIOIOWidth-1:0] iodatatohm3
);

    logic [AddrWidth-3:0]      busaddr_reg;
    logic [BusWidth-1:0]       busdata_in_reg;
    logic [2:0]                wr_sync;
    logic [2:0]                rd_sync;
    logic                      wr_stb;
    logic                      rd_stb;
    logic [PortsPerReg-1:0]    ddr_reg [NumIOReg];
    logic [PortsPerReg-1:0]    od_reg  [NumIOReg];
    logic [NumIOReg-1:0]       ddr_hit;
    logic [NumIOReg-1:0]       od_hit;
    logic [BusWidth-1:0]       rd_word;
    logic [MuxGPIOIOWidth-1:0] pad_meta;

    always_ff @(posedge CLOCK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            busaddr_reg    <= '0;
            busdata_in_reg <= '0;
        end else begin
            busaddr_reg    <= busaddress;
            busdata_in_reg <= busdata_in;
        end
    end

    // Sync chains reset high so a strobe held through reset release gives no edge.
    always_ff @(posedge CLOCK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            wr_sync <= 3'b111;
            rd_sync <= 3'b111;
        end else begin
            wr_sync <= {wr_sync[1:0], write_reg};
            rd_sync <= {rd_sync[1:0], read_reg};
        end
    end

    assign wr_stb = wr_sync[1] & ~wr_sync[2];
    assign rd_stb = rd_sync[1] & ~rd_sync[2];

    always_comb begin
        ddr_hit = '0;
        od_hit  = '0;
        rd_word = '0;
        for (int k = 0; k < NumIOReg; k++) begin
            if ({busaddr_reg, 2'b00} == AddrWidth'(DDRBase + 4 * k)) begin
                ddr_hit[k]               = 1'b1;
                rd_word[PortsPerReg-1:0] = ddr_reg[k];
            end
            if ({busaddr_reg, 2'b00} == AddrWidth'(ODBase + 4 * k)) begin
                od_hit[k]                = 1'b1;
                rd_word[PortsPerReg-1:0] = od_reg[k];
            end
        end
    end

    always_ff @(posedge CLOCK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            for (int k = 0; k < NumIOReg; k++) begin
                ddr_reg[k] <= '0;
                od_reg[k]  <= '0;
            end
        end else if (wr_stb) begin
            for (int k = 0; k < NumIOReg; k++) begin
                if (ddr_hit[k]) ddr_reg[k] <= busdata_in_reg[PortsPerReg-1:0];
                if (od_hit[k])  od_reg[k]  <= busdata_in_reg[PortsPerReg-1:0];
            end
        end
    end

    // Readback samples the registers on the same edge a coincident write commits,
    // so it returns the pre-write value.
    always_ff @(posedge CLOCK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            busdata_out <= '0;
            read_valid  <= 1'b0;
        end else begin
            read_valid <= rd_stb;
            if (rd_stb) busdata_out <= rd_word;
        end
    end

    always_comb begin
        oe      = '0;
        pad_out = '0;
        for (int i = 0; i < MuxGPIOIOWidth; i++) begin
            if (od_reg[i / PortsPerReg][i % PortsPerReg]) begin
                oe[i]      = ddr_reg[i / PortsPerReg][i % PortsPerReg] & ~iodatafromhm3[i];
                pad_out[i] = 1'b0;
            end else begin
                oe[i]      = ddr_reg[i / PortsPerReg][i % PortsPerReg];
                pad_out[i] = iodatafromhm3[i];
            end
        end
    end

    always_ff @(posedge CLOCK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            pad_meta    <= '0;
            iodatatohm3 <= '0;
        end else begin
            pad_meta    <= pad_in;
            iodatatohm3 <= pad_meta;
        end
    end

    // Bus bits above the register width are accepted but never stored.
    if (PortsPerReg < BusWidth) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^busdata_in_reg[BusWidth-1:PortsPerReg];
    end

endmodule

// File: tb/tb_gpio_ddr_od_regfile.sv
// Randomised self-checking bench for gpio_ddr_od_regfile against a register-array model.
module tb_gpio_ddr_od_regfile;

    logic        CLOCK = 1'b0;
    logic        reset_reg_N;
    logic        write_reg;
    logic        read_reg;
    logic [11:0] busaddress;
    logic [31:0] busdata_in;
    logic [31:0] busdata_out;
    logic        read_valid;
    logic [33:0] iodatafromhm3;
    logic [33:0] pad_in;
    logic [33:0] oe;
    logic [33:0] pad_out;
    logic [33:0] iodatatohm3;

    int total = 0;
    int bad   = 0;

    logic [23:0] ddr_m [6];
    logic [23:0] od_m  [6];

    gpio_ddr_od_regfile dut (
        .CLOCK         (CLOCK),
        .reset_reg_N   (reset_reg_N),
        .write_reg     (write_reg),
        .read_reg      (read_reg),
        .busaddress    (busaddress),
        .busdata_in    (busdata_in),
        .busdata_out   (busdata_out),
        .read_valid    (read_valid),
        .iodatafromhm3 (iodatafromhm3),
        .pad_in        (pad_in),
        .oe            (oe),
        .pad_out       (pad_out),
        .iodatatohm3   (iodatatohm3)
    );

    always #5 CLOCK = ~CLOCK;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Register index for a byte address: 0..5 DDR, 6..11 OD, -1 unmapped.
    function automatic int reg_idx(input logic [13:0] a);
        if (a[1:0] != 2'b00) return -1;
        if (a >= 14'h1100 && a < 14'h1118) return int'(a - 14'h1100) / 4;
        if (a >= 14'h1300 && a < 14'h1318) return 6 + int'(a - 14'h1300) / 4;
        return -1;
    endfunction

    function automatic void model_write(input logic [13:0] a, input logic [31:0] d);
        int idx = reg_idx(a);
        if (idx >= 0 && idx < 6) ddr_m[idx] = d[23:0];
        else if (idx >= 6) od_m[idx-6] = d[23:0];
    endfunction

    function automatic logic [31:0] model_read(input logic [13:0] a);
        int idx = reg_idx(a);
        if (idx < 0) return 32'h0;
        if (idx < 6) return {8'h00, ddr_m[idx]};
        return {8'h00, od_m[idx-6]};
    endfunction

    function automatic void model_pins(input logic [33:0] io, output logic [33:0] oe_e,
                                       output logic [33:0] pad_e);
        for (int i = 0; i < 34; i++) begin
            logic d, o;
            d = ddr_m[i/24][i%24];
            o = od_m[i/24][i%24];
            oe_e[i]  = o ? (d & ~io[i]) : d;
            pad_e[i] = o ? 1'b0 : io[i];
        end
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 6; k++) begin
            ddr_m[k] = '0;
            od_m[k]  = '0;
        end
    endfunction

    function automatic logic [13:0] reg_addr(input int idx);
        if (idx < 6) return 14'h1100 + 14'(4 * idx);
        return 14'h1300 + 14'(4 * (idx - 6));
    endfunction

    // Drives the strobe(s) just after a rising edge (edge N of the access).
    task automatic start_access(input logic [13:0] a, input logic [31:0] d,
                                input logic wr, input logic rd);
        @(posedge CLOCK);
        #1;
        busaddress = a[13:2];
        busdata_in = d;
        write_reg  = wr;
        read_reg   = rd;
    endtask

    // Holds the strobe, then releases it; counts read_valid pulses over a bounded window.
    task automatic finish_access(output int nvalid, output logic [31:0] rdata);
        nvalid = 0;
        rdata  = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLOCK);
            if (read_valid) begin
                nvalid++;
                rdata = busdata_out;
            end
            if (c == 5) begin
                write_reg = 1'b0;
                read_reg  = 1'b0;
            end
        end
    endtask

    task automatic do_write(input logic [13:0] a, input logic [31:0] d);
        int n;
        logic [31:0] r;
        start_access(a, d, 1'b1, 1'b0);
        finish_access(n, r);
        model_write(a, d);
    endtask

    task automatic do_read(input logic [13:0] a, output int n, output logic [31:0] r);
        start_access(a, 32'h0, 1'b0, 1'b1);
        finish_access(n, r);
    endtask

    task automatic test_reset();
        int nv = 0;
        int oe_seen = 0;
        int n;
        logic [31:0] r;
        reset_reg_N   = 1'b0;
        write_reg     = 1'b1;
        read_reg      = 1'b0;
        busaddress    = 12'h440;
        busdata_in    = 32'h00FF_FFFF;
        iodatafromhm3 = 34'h0;
        pad_in        = 34'h3_FFFF_FFFF;
        model_clear();
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        total++;
        if (busdata_out !== 32'h0 || read_valid !== 1'b0 || iodatatohm3 !== 34'h0 || oe !== 34'h0) begin
            bad++;
            $display("FAIL reset_state: bdo=%h rv=%b tohm3=%h oe=%h want all 0",
                     busdata_out, read_valid, iodatatohm3, oe);
        end
        pad_in = 34'h0;
        @(posedge CLOCK);
        #1 reset_reg_N = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLOCK);
            if (read_valid) nv++;
            if (oe !== 34'h0) oe_seen++;
        end
        total++;
        if (oe_seen != 0 || nv != 0 || busdata_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_release_held_strobe: oe_cycles=%0d valids=%0d bdo=%h want 0 0 0",
                     oe_seen, nv, busdata_out);
        end
        write_reg = 1'b0;
        repeat (4) @(posedge CLOCK);
        do_read(14'h1100, n, r);
        total++;
        if (r !== 32'h0 || n != 1) begin
            bad++;
            $display("FAIL reset_ddr0_read: data=%h valids=%0d want 0 1", r, n);
        end
    endtask

    task automatic test_write_latency();
        int n;
        logic [31:0] r;
        logic [33:0] oe_e, pad_e;
        iodatafromhm3 = 34'($urandom) ^ {$urandom_range(0, 3), 32'h0};
        start_access(14'h1100, 32'h00AB_CDEF, 1'b1, 1'b0);
        @(posedge CLOCK);
        @(posedge CLOCK);
        #1;
        total++;
        if (oe !== 34'h0) begin
            bad++;
            $display("FAIL write_early: oe=%h at edge N+2 want 0", oe);
        end
        @(posedge CLOCK);
        #1;
        total++;
        if (oe !== 34'h0_00AB_CDEF) begin
            bad++;
            $display("FAIL write_latency: oe=%h at edge N+3 want 00abcdef", oe);
        end
        finish_access(n, r);
        model_write(14'h1100, 32'h00AB_CDEF);
        do_write(14'h1104, 32'h0000_03FF);
        #1;
        total++;
        if (oe !== 34'h3FF_ABCDEF || pad_out !== iodatafromhm3) begin
            bad++;
            $display("FAIL write_two_regs: oe=%h pad_out=%h want 3ffabcdef %h", oe, pad_out, iodatafromhm3);
        end
        model_pins(iodatafromhm3, oe_e, pad_e);
        for (int k = 0; k < 12; k++) begin
            do_read(reg_addr(k), n, r);
            total++;
            if (r !== model_read(reg_addr(k)) || n != 1) begin
                bad++;
                $display("FAIL write_readback_%0d: data=%h valids=%0d want %h 1", k, r, n, model_read(reg_addr(k)));
            end
        end
    endtask

    task automatic test_open_drain();
        do_write(14'h1100, 32'h0000_0001);
        do_write(14'h1300, 32'h0000_0001);
        iodatafromhm3[0] = 1'b1;
        #1;
        total++;
        if (oe[0] !== 1'b0 || pad_out[0] !== 1'b0) begin
            bad++;
            $display("FAIL od_release: oe0=%b pad0=%b want 0 0", oe[0], pad_out[0]);
        end
        iodatafromhm3[0] = 1'b0;
        #1;
        total++;
        if (oe[0] !== 1'b1 || pad_out[0] !== 1'b0) begin
            bad++;
            $display("FAIL od_drive_low: oe0=%b pad0=%b want 1 0", oe[0], pad_out[0]);
        end
    endtask

    task automatic test_read_unmapped();
        int n;
        logic [31:0] r;
        do_write(14'h1104, 32'hFFFF_FFFF);
        do_read(14'h1104, n, r);
        total++;
        if (r !== 32'h00FF_FFFF || n != 1) begin
            bad++;
            $display("FAIL read_masked: data=%h valids=%0d want 00ffffff 1", r, n);
        end
        do_read(14'h1200, n, r);
        total++;
        if (r !== 32'h0 || n != 1) begin
            bad++;
            $display("FAIL read_unmapped: data=%h valids=%0d want 0 1", r, n);
        end
        do_write(14'h1200, $urandom);
        for (int k = 0; k < 12; k++) begin
            do_read(reg_addr(k), n, r);
            total++;
            if (r !== model_read(reg_addr(k))) begin
                bad++;
                $display("FAIL unmapped_write_reg%0d: data=%h want %h", k, r, model_read(reg_addr(k)));
            end
        end
    endtask

    task automatic test_simultaneous();
        int n;
        logic [31:0] r;
        do_write(14'h1108, 32'h0012_3456);
        start_access(14'h1108, 32'h0065_4321, 1'b1, 1'b1);
        finish_access(n, r);
        total++;
        if (r !== 32'h0012_3456 || n != 1) begin
            bad++;
            $display("FAIL simul_read_old: data=%h valids=%0d want 00123456 1", r, n);
        end
        model_write(14'h1108, 32'h0065_4321);
        do_read(14'h1108, n, r);
        total++;
        if (r !== 32'h0065_4321) begin
            bad++;
            $display("FAIL simul_write_commit: data=%h want 00654321", r);
        end
    endtask

    task automatic test_random();
        int n;
        logic [31:0] r, d;
        logic [13:0] a;
        logic [33:0] oe_e, pad_e;
        for (int t = 0; t < 40; t++) begin
            int sel = $urandom_range(0, 13);
            if (sel < 12) a = reg_addr(sel);
            else if (sel == 12) a = 14'h1200 + 14'(4 * $urandom_range(0, 63));
            else a = 14'h1118;
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d);
                iodatafromhm3 = {2'($urandom), 32'($urandom)};
                #1;
                model_pins(iodatafromhm3, oe_e, pad_e);
                total++;
                if (oe !== oe_e || pad_out !== pad_e) begin
                    bad++;
                    $display("FAIL rand_pins a=%h: oe=%h pad=%h want %h %h", a, oe, pad_out, oe_e, pad_e);
                end
            end else begin
                do_read(a, n, r);
                total++;
                if (r !== model_read(a) || n != 1) begin
                    bad++;
                    $display("FAIL rand_read a=%h: data=%h valids=%0d want %h 1", a, r, n, model_read(a));
                end
            end
        end
    endtask

    task automatic test_pad_sync();
        for (int p = 0; p < 2; p++) begin
            logic v = (p == 0);
            @(posedge CLOCK);
            #1 pad_in[33] = v;
            @(posedge CLOCK);
            #1;
            total++;
            if (iodatatohm3[33] !== ~v) begin
                bad++;
                $display("FAIL pad_sync_early: got %b want %b", iodatatohm3[33], ~v);
            end
            @(posedge CLOCK);
            #1;
            total++;
            if (iodatatohm3[33] !== v) begin
                bad++;
                $display("FAIL pad_sync_2: got %b want %b", iodatatohm3[33], v);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int nv = 0;
        int n;
        logic [31:0] r;
        do_write(14'h110C, 32'h00C0_FFEE);
        do_read(14'h110C, n, r);
        iodatafromhm3 = 34'h0;
        pad_in        = 34'h1_2345_6789;
        start_access(14'h110C, 32'h0, 1'b0, 1'b1);
        @(posedge CLOCK);
        #3 reset_reg_N = 1'b0;
        model_clear();
        for (int c = 0; c < 4; c++) begin
            @(negedge CLOCK);
            if (read_valid) nv++;
        end
        total++;
        if (oe !== 34'h0 || pad_out !== 34'h0 || busdata_out !== 32'h0 || iodatatohm3 !== 34'h0) begin
            bad++;
            $display("FAIL reset_mid_outputs: oe=%h pad=%h bdo=%h tohm3=%h want all 0",
                     oe, pad_out, busdata_out, iodatatohm3);
        end
        @(posedge CLOCK);
        #1 reset_reg_N = 1'b1;
        pad_in = 34'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLOCK);
            if (read_valid) nv++;
        end
        total++;
        if (nv != 0) begin
            bad++;
            $display("FAIL reset_mid_valid: read_valid pulses=%0d want 0", nv);
        end
        read_reg = 1'b0;
        repeat (4) @(posedge CLOCK);
        do_read(14'h110C, n, r);
        total++;
        if (r !== 32'h0 || n != 1) begin
            bad++;
            $display("FAIL reset_mid_cleared: data=%h valids=%0d want 0 1", r, n);
        end
    endtask

    initial begin
        test_reset();
        test_write_latency();
        test_open_drain();
        test_read_unmapped();
        test_simultaneous();
        test_random();
        test_pad_sync();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
